// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      HALT,
      ERROR
   } fetch_state_t;

   // syscall encoding doubles as the halt marker
   localparam logic [31:0] HALT_WORD = 32'h0000000C;

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer: owns the PC, drives the word address of a combinational
// instruction memory and hands instructions to decode through a one-entry valid/ready slot.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter int unsigned           DATA_WIDTH = 32,
   parameter int unsigned           MEM_WORDS  = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic [DATA_WIDTH-1:0] imem_data,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_instr,
   output logic [ADDR_WIDTH-1:0] out_pc,
   output logic                  halted,
   output logic                  fetch_err
);

   fetch_state_t          state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic                  out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0] out_instr_q, out_instr_d;
   logic [ADDR_WIDTH-1:0] out_pc_q, out_pc_d;
   logic                  halted_q, halted_d;
   logic                  fetch_err_q, fetch_err_d;

   logic [ADDR_WIDTH-1:0] word_idx;
   logic                  transfer;
   logic                  slot_free;
   logic                  out_of_range;
   logic                  redirect_misaligned;

   assign word_idx            = {2'b00, pc_q[ADDR_WIDTH-1:2]};
   assign transfer            = out_valid_q && out_ready;
   assign slot_free           = !out_valid_q || transfer;
   assign out_of_range        = word_idx >= ADDR_WIDTH'(MEM_WORDS);
   assign redirect_misaligned = redirect_pc[1:0] != 2'b00;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         pc_q        <= RESET_PC;
         out_valid_q <= 1'b0;
         out_instr_q <= '0;
         out_pc_q    <= '0;
         halted_q    <= 1'b0;
         fetch_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         out_valid_q <= out_valid_d;
         out_instr_q <= out_instr_d;
         out_pc_q    <= out_pc_d;
         halted_q    <= halted_d;
         fetch_err_q <= fetch_err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      out_valid_d = out_valid_q;
      out_instr_d = out_instr_q;
      out_pc_d    = out_pc_q;
      halted_d    = halted_q;
      fetch_err_d = fetch_err_q;

      // A delivered entry is consumed regardless of what else happens this cycle
      if (transfer) begin
         out_valid_d = 1'b0;
      end

      unique case (state_q)
         IDLE: begin
            state_d = RUN;
         end
         RUN: begin
            if (redirect_valid) begin
               out_valid_d = 1'b0;
               if (redirect_misaligned) begin
                  state_d     = ERROR;
                  fetch_err_d = 1'b1;
               end else begin
                  pc_d = redirect_pc;
               end
            end else if (out_of_range) begin
               state_d     = ERROR;
               fetch_err_d = 1'b1;
            end else if (slot_free) begin
               out_instr_d = imem_data;
               out_pc_d    = pc_q;
               out_valid_d = 1'b1;
               pc_d        = pc_q + ADDR_WIDTH'(4);
               if (imem_data == DATA_WIDTH'(HALT_WORD)) begin
                  state_d  = HALT;
                  halted_d = 1'b1;
               end
            end
         end
         HALT, ERROR: begin
            if (redirect_valid && redirect_misaligned) begin
               fetch_err_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      imem_addr = word_idx;
      out_valid = out_valid_q;
      out_instr = out_instr_q;
      out_pc    = out_pc_q;
      halted    = halted_q;
      fetch_err = fetch_err_q;
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a combinational memory array standing in for instr_memory.
module tb_fetch_unit;
   import fetch_pkg::*;

   logic        clk;
   logic        rst;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        halted;
   logic        fetch_err;

   logic [31:0] mem [0:63];
   int          checks;
   int          errors;

   assign imem_data = mem[imem_addr[5:0]];

   fetch_unit #(
      .ADDR_WIDTH(32),
      .DATA_WIDTH(32),
      .MEM_WORDS (32),
      .RESET_PC  (32'h0)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .imem_addr     (imem_addr),
      .imem_data     (imem_data),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_instr     (out_instr),
      .out_pc        (out_pc),
      .halted        (halted),
      .fetch_err     (fetch_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Leaves time at posedge+1 with rst just released; the next edge is the IDLE cycle
   task automatic do_reset();
      rst            = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      checks    = 0;
      errors    = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 64; i++) begin
         mem[i] = (i < 32) ? 32'(32'h11 * (i + 1)) : 32'hDEAD_BEEF;
      end

      // Reset values and streaming throughput
      do_reset();
      check("rst_valid", {31'b0, out_valid}, 32'h0);
      check("rst_addr", imem_addr, 32'h0);
      check("rst_pc", out_pc, 32'h0);
      check("rst_instr", out_instr, 32'h0);
      check("rst_halted", {31'b0, halted}, 32'h0);
      check("rst_err", {31'b0, fetch_err}, 32'h0);
      step();
      check("idle_valid", {31'b0, out_valid}, 32'h0);
      step();
      check("first_valid", {31'b0, out_valid}, 32'h1);
      check("first_pc", out_pc, 32'h0);
      check("first_instr", out_instr, 32'h11);
      step();
      check("seq1_pc", out_pc, 32'h4);
      check("seq1_instr", out_instr, 32'h22);
      step();
      check("seq2_pc", out_pc, 32'h8);
      check("seq2_instr", out_instr, 32'h33);

      // Backpressure holds the slot and the PC
      do_reset();
      step();
      step();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall_valid", {31'b0, out_valid}, 32'h1);
         check("stall_pc", out_pc, 32'h0);
         check("stall_instr", out_instr, 32'h11);
         check("stall_addr", imem_addr, 32'h1);
      end
      out_ready = 1'b1;
      step();
      check("resume_pc", out_pc, 32'h4);
      check("resume_instr", out_instr, 32'h22);
      step();
      check("resume2_pc", out_pc, 32'h8);

      // Aligned redirect: one bubble, then the target
      do_reset();
      repeat (4) step();
      check("redir_pre_pc", out_pc, 32'h8);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h40;
      step();
      redirect_valid = 1'b0;
      check("redir_bubble", {31'b0, out_valid}, 32'h0);
      check("redir_addr", imem_addr, 32'h10);
      step();
      check("redir_valid", {31'b0, out_valid}, 32'h1);
      check("redir_pc", out_pc, 32'h40);
      check("redir_instr", out_instr, 32'h121);
      step();
      check("redir_next_pc", out_pc, 32'h44);

      // Misaligned redirect
      do_reset();
      repeat (4) step();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h42;
      step();
      redirect_valid = 1'b0;
      check("mis_err", {31'b0, fetch_err}, 32'h1);
      check("mis_valid", {31'b0, out_valid}, 32'h0);
      check("mis_state", 32'(dut.state_q), 32'(ERROR));
      step();
      check("mis_hold_valid", {31'b0, out_valid}, 32'h0);
      check("mis_hold_addr", imem_addr, 32'h3);

      // Halt word at index 3
      mem[3] = HALT_WORD;
      do_reset();
      repeat (5) step();
      check("halt_valid", {31'b0, out_valid}, 32'h1);
      check("halt_pc", out_pc, 32'hC);
      check("halt_instr", out_instr, 32'hC);
      check("halt_flag", {31'b0, halted}, 32'h1);
      step();
      check("halt_drain", {31'b0, out_valid}, 32'h0);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h40;
      step();
      redirect_valid = 1'b0;
      step();
      check("halt_ign_valid", {31'b0, out_valid}, 32'h0);
      check("halt_ign_addr", imem_addr, 32'h4);
      check("halt_no_err", {31'b0, fetch_err}, 32'h0);
      mem[3] = 32'h44;

      // Running off the end of memory
      do_reset();
      repeat (33) step();
      check("end_pc", out_pc, 32'h7C);
      check("end_instr", out_instr, 32'h220);
      check("end_err_pre", {31'b0, fetch_err}, 32'h0);
      step();
      check("oor_err", {31'b0, fetch_err}, 32'h1);
      check("oor_valid", {31'b0, out_valid}, 32'h0);
      check("oor_addr", imem_addr, 32'h20);
      step();
      check("oor_hold", {31'b0, out_valid}, 32'h0);

      // Asynchronous reset mid-stream
      do_reset();
      repeat (4) step();
      check("async_pre_pc", out_pc, 32'h8);
      #2;
      rst = 1'b1;
      #1;
      check("async_valid", {31'b0, out_valid}, 32'h0);
      check("async_addr", imem_addr, 32'h0);
      check("async_pc", out_pc, 32'h0);
      #1;
      rst = 1'b0;
      step();
      check("restart_idle", {31'b0, out_valid}, 32'h0);
      step();
      check("restart_pc", out_pc, 32'h0);
      check("restart_instr", out_instr, 32'h11);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
